// File: rtl/ofdm_pkg.sv
// ofdm_pkg: shared constants, FSM state type and modulation helpers for the
// OFDM transmit scheduler.
// Contents: modulation code constants, state enum, code-to-bits mapping.
package ofdm_pkg;

  localparam int N_DATA_SC_DEF = 200;

  localparam logic [2:0] MOD_BPSK   = 3'b000;
  localparam logic [2:0] MOD_QPSK   = 3'b001;
  localparam logic [2:0] MOD_QAM16  = 3'b010;
  localparam logic [2:0] MOD_QAM64  = 3'b011;
  localparam logic [2:0] MOD_QAM256 = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_FEED,
    ST_PAD,
    ST_DRAIN
  } state_t;

  // Bits carried per data subcarrier; 0 flags an invalid code.
  function automatic int unsigned mod_bits(input logic [2:0] code);
    case (code)
      MOD_BPSK:   return 1;
      MOD_QPSK:   return 2;
      MOD_QAM16:  return 4;
      MOD_QAM64:  return 6;
      MOD_QAM256: return 8;
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/ofdm_tx_sched_if.sv
// ofdm_tx_sched_if: request, byte-source, modulator and status signals of the
// OFDM transmit scheduler.
// Modports: master = frame requester / byte source / modulator side,
//           slave  = the scheduler itself.
interface ofdm_tx_sched_if #(
  parameter int LEN_W = 16,
  parameter int SYM_W = 12
);
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic [2:0]       i_modulation;
  logic             i_abort;
  logic             i_src_valid;
  logic [7:0]       i_src_data;
  logic             o_src_ready;
  logic             o_mod_valid;
  logic [7:0]       o_mod_data;
  logic [2:0]       o_modulation;
  logic             i_mod_ready;
  logic             i_sym_done;
  logic             o_busy;
  logic             o_done;
  logic             o_error;
  logic [SYM_W-1:0] o_sym_count;

  modport master (
    output i_start, i_len, i_modulation, i_abort, i_src_valid, i_src_data,
           i_mod_ready, i_sym_done,
    input  o_src_ready, o_mod_valid, o_mod_data, o_modulation, o_busy,
           o_done, o_error, o_sym_count
  );

  modport slave (
    input  i_start, i_len, i_modulation, i_abort, i_src_valid, i_src_data,
           i_mod_ready, i_sym_done,
    output o_src_ready, o_mod_valid, o_mod_data, o_modulation, o_busy,
           o_done, o_error, o_sym_count
  );
endinterface

// File: rtl/ofdm_sym_calc.sv
// ofdm_sym_calc: symbols = ceil(len/bps) and pad = symbols*bps - len by
// repeated subtraction, one subtraction per clock (no divider).
// Latency: ceil(len/bps) clocks from i_start to the o_done pulse.
// Ports: i_start loads i_len; i_bps must be stable while running;
//        i_abort cancels; o_syms/o_pad hold results after o_done.
module ofdm_sym_calc #(
  parameter int LEN_W = 16,
  parameter int SYM_W = 12
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [LEN_W-1:0] i_len,
  input  logic [LEN_W-1:0] i_bps,
  output logic             o_done,
  output logic [SYM_W-1:0] o_syms,
  output logic [LEN_W-1:0] o_pad
);
  logic [LEN_W-1:0] rem;
  logic             run;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rem    <= '0;
      run    <= 1'b0;
      o_done <= 1'b0;
      o_syms <= '0;
      o_pad  <= '0;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        run <= 1'b0;
      end else if (i_start) begin
        rem    <= i_len;
        o_syms <= '0;
        o_pad  <= '0;
        run    <= 1'b1;
      end else if (run) begin
        o_syms <= o_syms + 1'b1;
        // Last (possibly partial) symbol: the shortfall becomes padding.
        if (rem <= i_bps) begin
          o_pad  <= i_bps - rem;
          run    <= 1'b0;
          o_done <= 1'b1;
        end else begin
          rem <= rem - i_bps;
        end
      end
    end
  end

endmodule

// File: rtl/ofdm_tx_sched.sv
// ofdm_tx_sched: sequences one OFDM payload frame: validate request, size it
// in whole symbols, stream source bytes then 8'h00 padding to the modulator,
// and wait for the matching number of symbol-done pulses.
// Latency: CALC takes ceil(len/BPS)+1 clocks; one clock source-to-modulator.
// Backpressure: single holding register; source ready only when it is empty
// or draining this cycle. Optional macro OFDM_TX_SCHED_WATCHDOG_EN adds a
// stall watchdog (WDT_CYCLES) that behaves like i_abort.
// Ports: i_clk, i_reset (async, active high), bus (slave modport).
module ofdm_tx_sched
  import ofdm_pkg::*;
#(
  parameter int N_DATA_SC  = N_DATA_SC_DEF,
  parameter int LEN_W      = 16,
  parameter int SYM_W      = 12,
  parameter int WDT_CYCLES = 65535
) (
  input  logic           i_clk,
  input  logic           i_reset,
  ofdm_tx_sched_if.slave bus
);
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [2:0]       mod_q;
  logic             hold_vld;
  logic [7:0]       hold_dat;
  logic [LEN_W:0]   cnt_q;      // bytes loaded into the holding register
  logic [SYM_W-1:0] sym_cnt;
  logic             done_q, done_d, err_q, err_d;
  logic [LEN_W-1:0] bps, pad;
  logic [SYM_W-1:0] syms;
  logic [LEN_W:0]   total;
  logic             calc_done, busy, req_ok, accept, abort_take, wdt_hit;
  logic             hold_free, src_rdy, src_fire, pad_ld, mod_fire;

  assign busy      = (state_q != ST_IDLE);
  assign bps       = LEN_W'((N_DATA_SC / 8) * mod_bits(mod_q));
  assign total     = {1'b0, len_q} + {1'b0, pad};
  assign req_ok    = (bus.i_len != '0) && (mod_bits(bus.i_modulation) != 0);
  assign accept    = (state_q == ST_IDLE) && bus.i_start && req_ok;
  assign abort_take = busy && (bus.i_abort || wdt_hit);
  assign hold_free = !hold_vld || bus.i_mod_ready;
  assign src_rdy   = (state_q == ST_FEED) && (cnt_q < {1'b0, len_q}) && hold_free;
  assign src_fire  = src_rdy && bus.i_src_valid;
  assign pad_ld    = (state_q == ST_PAD) && (cnt_q < total) && hold_free;
  assign mod_fire  = hold_vld && bus.i_mod_ready;

  ofdm_sym_calc #(.LEN_W(LEN_W), .SYM_W(SYM_W)) u_calc (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (accept),
    .i_abort (abort_take),
    .i_len   (bus.i_len),
    .i_bps   (bps),
    .o_done  (calc_done),
    .o_syms  (syms),
    .o_pad   (pad)
  );

`ifdef OFDM_TX_SCHED_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  logic [WDT_W-1:0] wdt_q;

  // Any forward progress (byte handshake or symbol pulse) restarts the count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wdt_q <= '0;
    end else if (!busy || src_fire || pad_ld || mod_fire || bus.i_sym_done) begin
      wdt_q <= '0;
    end else if (!wdt_hit) begin
      wdt_q <= wdt_q + 1'b1;
    end
  end

  assign wdt_hit = busy && (wdt_q == WDT_W'(WDT_CYCLES));
`else
  assign wdt_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          if (req_ok) state_d = ST_CALC;
          else        err_d   = 1'b1;
        end
      end
      ST_CALC: if (calc_done) state_d = ST_FEED;
      ST_FEED: begin
        // With padding the last data byte may still sit in the register;
        // PAD keeps presenting it before the zeros.
        if (cnt_q == {1'b0, len_q}) begin
          if (pad != '0)     state_d = ST_PAD;
          else if (hold_free) state_d = ST_DRAIN;
        end
      end
      ST_PAD: if ((cnt_q == total) && hold_free) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (sym_cnt >= syms) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort_take) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      mod_q    <= 3'b000;
      hold_vld <= 1'b0;
      hold_dat <= 8'h00;
      cnt_q    <= '0;
      sym_cnt  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (accept) begin
        len_q   <= bus.i_len;
        mod_q   <= bus.i_modulation;
        cnt_q   <= '0;
        sym_cnt <= '0;
      end else if (src_fire || pad_ld) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (abort_take) begin
        hold_vld <= 1'b0;
      end else if (src_fire) begin
        hold_vld <= 1'b1;
        hold_dat <= bus.i_src_data;
      end else if (pad_ld) begin
        hold_vld <= 1'b1;
        hold_dat <= 8'h00;
      end else if (mod_fire) begin
        hold_vld <= 1'b0;
      end
      if (busy && bus.i_sym_done && (sym_cnt != '1)) begin
        sym_cnt <= sym_cnt + 1'b1;
      end
    end
  end

  assign bus.o_src_ready  = src_rdy;
  assign bus.o_mod_valid  = hold_vld;
  assign bus.o_mod_data   = hold_dat;
  assign bus.o_modulation = mod_q;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done_q;
  assign bus.o_error      = err_q;
  assign bus.o_sym_count  = sym_cnt;

endmodule

// File: tb/tb_ofdm_tx_sched.sv
// tb_ofdm_tx_sched: randomized frames against a byte-stream / symbol-count
// reference model, plus rejects, abort, async reset and stall cases.
module tb_ofdm_tx_sched;
  localparam int LEN_W = 16;
  localparam int SYM_W = 12;
`ifdef OFDM_TX_SCHED_WATCHDOG_EN
  localparam int WDT = 100;
`else
  localparam int WDT = 65535;
`endif

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;

  ofdm_tx_sched_if #(.LEN_W(LEN_W), .SYM_W(SYM_W)) bus ();

  ofdm_tx_sched #(
    .N_DATA_SC  (200),
    .LEN_W      (LEN_W),
    .SYM_W      (SYM_W),
    .WDT_CYCLES (WDT)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bytes per symbol with 200 data subcarriers: 200 * bits / 8.
  function automatic int bps_of(input int code);
    int bits;
    bits = (code == 0) ? 1 : 2 * code;
    return 200 * bits / 8;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic quiet();
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_src_valid = 1'b0;
    bus.i_src_data  = 8'h00;
    bus.i_mod_ready = 1'b0;
    bus.i_sym_done  = 1'b0;
  endtask

  task automatic request(input int len, input int code);
    bus.i_len        = LEN_W'(len);
    bus.i_modulation = 3'(code);
    bus.i_start      = 1'b1;
    tick();
    bus.i_start = 1'b0;
  endtask

  task automatic run_frame(input int len, input int code, input bit bp, input bit inject);
    byte unsigned exp_q[$];
    int due_q[$];
    int bps, nsym, npad, total;
    int sidx, rcv, mism, stab, pad_zero, dones, errs, early, pulses, lat, cyc;
    bit prev_stall, injected;
    logic [7:0] prev_dat;
    bps  = bps_of(code);
    nsym = (len + bps - 1) / bps;
    npad = nsym * bps - len;
    total = len + npad;
    for (int i = 0; i < total; i++) exp_q.push_back(i < len ? 8'($urandom) : 8'h00);
    sidx = 0; rcv = 0; mism = 0; stab = 0; pad_zero = 0; dones = 0; errs = 0;
    early = 0; pulses = 0; lat = -1; cyc = 0;
    prev_stall = 1'b0; injected = 1'b0; prev_dat = 8'h00;
    request(len, code);
    while (cyc < 20000) begin
      cyc++;
      if (prev_stall && (!bus.o_mod_valid || bus.o_mod_data != prev_dat)) stab++;
      if (bus.o_error) begin errs++; break; end
      if (bus.o_done) begin
        dones++;
        if (pulses < nsym) early++;
        break;
      end
      bus.i_mod_ready = bp ? ((cyc / 3) % 2 == 0) : 1'b1;
      bus.i_src_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_src_data  = (sidx < len) ? exp_q[sidx] : 8'($urandom);
      bus.i_sym_done  = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        bus.i_sym_done = 1'b1;
        pulses++;
      end
      bus.i_start = 1'b0;
      if (inject && !injected && lat > 0 && sidx >= len / 2) begin
        bus.i_start = 1'b1; bus.i_len = 16'd5; bus.i_modulation = 3'd4;
        injected = 1'b1;
      end
      #1;
      if (lat < 0 && bus.o_src_ready) lat = cyc;
      if (bus.i_src_valid && bus.o_src_ready) sidx++;
      if (bus.o_mod_valid && bus.i_mod_ready) begin
        if (rcv >= total || bus.o_mod_data != exp_q[rcv]) mism++;
        else if (rcv >= len) pad_zero++;
        rcv++;
        if (rcv % bps == 0) due_q.push_back(cyc + 2);
      end
      prev_stall = bus.o_mod_valid && !bus.i_mod_ready;
      prev_dat   = bus.o_mod_data;
      tick();
    end
    quiet();
    chk("frame_done", dones, 1);
    chk("frame_err", errs, 0);
    chk("calc_latency", lat, nsym + 2);
    chk("bytes_out", rcv, total);
    chk("byte_mismatch", mism, 0);
    chk("pad_zeros", pad_zero, npad);
    chk("hold_stable", stab, 0);
    chk("done_early", early, 0);
    chk("sym_count", bus.o_sym_count, nsym);
    chk("mod_code", bus.o_modulation, code);
    tick();
    chk("done_pulse", bus.o_done, 0);
    chk("idle_busy", bus.o_busy, 0);
  endtask

  // Start a BPSK frame and push exactly 37 source bytes.
  task automatic feed_37();
    int cnt;
    cnt = 0;
    request(100, 0);
    for (int c = 0; c < 200 && cnt < 37; c++) begin
      bus.i_src_valid = 1'b1;
      bus.i_mod_ready = 1'b1;
      bus.i_src_data  = 8'($urandom);
      #1;
      if (bus.i_src_valid && bus.o_src_ready) cnt++;
      tick();
    end
    bus.i_src_valid = 1'b0;
    chk("bytes_before_abort", cnt, 37);
  endtask

  task automatic reject(input int len, input int code);
    request(len, code);
    chk("reject_err", bus.o_error, 1);
    chk("reject_busy", bus.o_busy, 0);
    tick();
    chk("reject_err_pulse", bus.o_error, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  initial begin
    int errs;
    bus.i_len = '0;
    bus.i_modulation = 3'b000;
    quiet();
    #1;
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_error", bus.o_error, 0);
    chk("rst_src_ready", bus.o_src_ready, 0);
    chk("rst_mod_valid", bus.o_mod_valid, 0);
    chk("rst_modulation", bus.o_modulation, 0);
    chk("rst_sym_count", bus.o_sym_count, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    tick();

    run_frame(200, 4, 1'b0, 1'b0);
    bus.i_sym_done = 1'b1;
    tick();
    bus.i_sym_done = 1'b0;
    chk("idle_sym_ignored", bus.o_sym_count, 1);

    run_frame(120, 1, 1'b0, 1'b1);
    run_frame(1, 0, 1'b1, 1'b0);
    run_frame(150, 3, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) run_frame($urandom_range(1, 400), $urandom_range(0, 4), 1'b1, 1'b0);

    reject(0, 2);
    reject(50, 7);

    bus.i_abort = 1'b1;
    request(10, 2);
    chk("start_beats_abort_busy", bus.o_busy, 1);
    chk("start_beats_abort_err", bus.o_error, 0);
    tick();
    bus.i_abort = 1'b0;
    chk("abort_calc_busy", bus.o_busy, 0);
    chk("abort_calc_err", bus.o_error, 1);
    tick();

    feed_37();
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_busy", bus.o_busy, 0);
    chk("abort_err", bus.o_error, 1);
    chk("abort_done", bus.o_done, 0);
    chk("abort_mod_valid", bus.o_mod_valid, 0);
    tick();
    chk("abort_err_pulse", bus.o_error, 0);

    feed_37();
    chk("pre_reset_busy", bus.o_busy, 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("arst_busy", bus.o_busy, 0);
    chk("arst_mod_valid", bus.o_mod_valid, 0);
    chk("arst_src_ready", bus.o_src_ready, 0);
    chk("arst_sym_count", bus.o_sym_count, 0);
    chk("arst_modulation", bus.o_modulation, 0);
    @(negedge i_clk);
    i_reset = 1'b0;
    tick();

    // Stall the modulator with a byte held.
    errs = 0;
    request(60, 0);
    bus.i_src_valid = 1'b1;
    bus.i_mod_ready = 1'b0;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (bus.o_error) errs++;
    end
    bus.i_src_valid = 1'b0;
`ifdef OFDM_TX_SCHED_WATCHDOG_EN
    chk("wdt_error", errs, 1);
    chk("wdt_idle", bus.o_busy, 0);
`else
    chk("stall_no_error", errs, 0);
    chk("stall_busy", bus.o_busy, 1);
    chk("stall_mod_valid", bus.o_mod_valid, 1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("stall_abort_err", bus.o_error, 1);
`endif
    tick();

    run_frame(250, 2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
